// File: rtl/fp_add_pkg.sv
// Shared types and constants for the binary32 add/subtract sequencer.
// Rounding build option: FP_ADD_RNE_EN (defined = round-to-nearest-even,
// undefined = truncate toward zero).
package fp_add_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int EXT_W  = 27;   // {hidden, frac[22:0], guard, round, sticky}

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    // Assemble a binary32 word from its fields.
    function automatic logic [31:0] fp_pack(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand / result handshake bundle of the fp add sequencer.
// master = ALU operand side + result consumer, slave = sequencer.
interface fp_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Sum;

    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, Sum
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, Sum
    );
endinterface

// File: rtl/fp_align_shifter.sv
// Right shifter for the 27-bit extended mantissa of the smaller operand.
// Every bit shifted past the sticky position is ORed into bit 0.
module fp_align_shifter
    import fp_add_pkg::*;
(
    input  logic [EXT_W-1:0] din,
    input  logic [4:0]       shamt,   // 0..27, capped by the caller
    output logic [EXT_W-1:0] dout
);

    logic [2*EXT_W-1:0] wide;

    // Shift into a double-width window; the lower half is the lost part.
    always_comb begin
        wide = {din, {EXT_W{1'b0}}} >> shamt;
        dout = {wide[2*EXT_W-1:EXT_W+1], wide[EXT_W] | (|wide[EXT_W-1:0])};
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 add/subtract: UNPACK -> ALIGN -> ADD -> NORM -> ROUND
// over one shared mantissa register. Denormals flush to zero.
// Build option FP_ADD_RNE_EN selects round-to-nearest-even, else truncate.
module fp_add_sequencer
    import fp_add_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fp_add_sequencer_if.slave   bus,
    output logic                busy
);

    state_t             state;
    logic [31:0]        a_r, b_r;        // b_r carries the effective sign
    logic               sign_r, eff_sub;
    logic [EXP_W-1:0]   exp_l, exp_s;
    logic [FRAC_W-1:0]  frac_l, frac_s;
    logic [EXP_W:0]     exp_r;           // one spare bit for overflow detect
    logic [EXT_W:0]     acc;             // bit 27 catches the add carry
    logic [EXT_W-1:0]   mant_s;

    // Operand field decode
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;

    assign ea     = a_r[30:23];
    assign eb     = b_r[30:23];
    assign fa     = a_r[22:0];
    assign fb     = b_r[22:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);
    assign swap   = (b_r[30:0] > a_r[30:0]);

    logic        special;
    logic [31:0] special_res;

    // Early-exit results resolved in UNPACK, in priority order
    always_comb begin
        special     = 1'b1;
        special_res = QNAN;
        if (a_nan || b_nan || (a_inf && b_inf && (a_r[31] != b_r[31])))
            special_res = QNAN;
        else if (a_inf)
            special_res = a_r;
        else if (b_inf)
            special_res = b_r;
        else if (a_zero && b_zero)
            special_res = fp_pack(a_r[31] & b_r[31], '0, '0);
        else if (a_zero)
            special_res = b_r;
        else if (b_zero)
            special_res = a_r;
        else
            special = 1'b0;
    end

    // Alignment: distance capped at 27, everything past that is sticky
    logic [EXP_W-1:0] exp_diff;
    logic [4:0]       shamt;
    logic [EXT_W-1:0] s_aligned;

    assign exp_diff = exp_l - exp_s;
    assign shamt    = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];

    fp_align_shifter u_align (
        .din   ({1'b1, frac_s, 3'b000}),
        .shamt (shamt),
        .dout  (s_aligned)
    );

    // Signed-magnitude add; |L| >= |S| so the difference never goes negative
    logic [EXT_W:0] add_res;
    assign add_res = eff_sub ? ({1'b0, acc[EXT_W-1:0]} - {1'b0, mant_s})
                             : ({1'b0, acc[EXT_W-1:0]} + {1'b0, mant_s});

    // Rounding increment from guard/round/sticky
    logic rnd_inc;
`ifdef FP_ADD_RNE_EN
    assign rnd_inc = acc[2] & (acc[1] | acc[0] | acc[3]);
`else
    assign rnd_inc = 1'b0;
`endif

    logic [FRAC_W+1:0] rnd_mant;
    logic [EXP_W:0]    rnd_exp;
    logic [FRAC_W-1:0] rnd_frac;

    assign rnd_mant = {1'b0, acc[EXT_W-1:3]} + (FRAC_W+2)'(rnd_inc);
    assign rnd_exp  = exp_r + (EXP_W+1)'(rnd_mant[FRAC_W+1]);
    assign rnd_frac = rnd_mant[FRAC_W+1] ? rnd_mant[FRAC_W:1] : rnd_mant[FRAC_W-1:0];

    // Sequencer FSM with registered handshake outputs and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.Sum       <= '0;
            busy          <= 1'b0;
            a_r           <= '0;
            b_r           <= '0;
            sign_r        <= 1'b0;
            eff_sub       <= 1'b0;
            exp_l         <= '0;
            exp_s         <= '0;
            frac_l        <= '0;
            frac_s        <= '0;
            exp_r         <= '0;
            acc           <= '0;
            mant_s        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r          <= bus.A;
                        b_r          <= {bus.B[31] ^ bus.sub, bus.B[30:0]};
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        bus.Sum       <= special_res;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        eff_sub <= a_r[31] ^ b_r[31];
                        if (swap) begin
                            sign_r <= b_r[31];
                            exp_l  <= eb;
                            frac_l <= fb;
                            exp_s  <= ea;
                            frac_s <= fa;
                        end else begin
                            sign_r <= a_r[31];
                            exp_l  <= ea;
                            frac_l <= fa;
                            exp_s  <= eb;
                            frac_s <= fb;
                        end
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    acc    <= {2'b01, frac_l, 3'b000};
                    mant_s <= s_aligned;
                    exp_r  <= {1'b0, exp_l};
                    state  <= ADD;
                end
                ADD: begin
                    if (add_res == '0) begin
                        bus.Sum       <= '0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        acc   <= add_res;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (acc[EXT_W]) begin
                        // carry out: single right shift, keep sticky
                        acc   <= {1'b0, acc[EXT_W:2], acc[1] | acc[0]};
                        exp_r <= exp_r + 1'b1;
                        state <= ROUND;
                    end else if (!acc[EXT_W-1]) begin
                        if (exp_r == 9'd1) begin
                            bus.Sum       <= fp_pack(sign_r, '0, '0);
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            acc   <= {acc[EXT_W-1:0], 1'b0};
                            exp_r <= exp_r - 1'b1;
                            // look ahead so NORM lasts exactly the shift count
                            if (acc[EXT_W-2])
                                state <= ROUND;
                        end
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd_exp >= {1'b0, EXP_MAX})
                        bus.Sum <= fp_pack(sign_r, EXP_MAX, '0);
                    else
                        bus.Sum <= fp_pack(sign_r, rnd_exp[EXP_W-1:0], rnd_frac);
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer: directed cases, randomized ops
// against an exact-arithmetic reference model, backpressure and mid-op reset.
module tb_fp_add_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    fp_add_sequencer_if bus();

    fp_add_sequencer dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum of the aligned operands, then rounding.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, output logic [31:0] res,
                                    output int lat);
        logic [31:0] bb, big, sml;
        int          ea, eb, el, es, d, p, e;
        logic [63:0] lv, sv, r, mant, rem, half;
        logic        inc;
        bb  = {b[31] ^ s, b[30:0]};
        ea  = int'(a[30:23]);
        eb  = int'(bb[30:23]);
        lat = 2;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && bb[22:0] != 0) ||
            (ea == 255 && eb == 255 && a[31] != bb[31])) begin
            res = 32'h7FC00000;
        end else if (ea == 255) begin
            res = a;
        end else if (eb == 255) begin
            res = bb;
        end else if (ea == 0 && eb == 0) begin
            res = {a[31] & bb[31], 31'b0};
        end else if (ea == 0) begin
            res = bb;
        end else if (eb == 0) begin
            res = a;
        end else begin
            if (bb[30:0] > a[30:0]) begin big = bb; sml = a; end
            else begin big = a; sml = bb; end
            el = int'(big[30:23]);
            es = int'(sml[30:23]);
            d  = el - es;
            lv = {40'b0, 1'b1, big[22:0]} << 38;
            sv = (d > 38) ? 64'd1 : ({40'b0, 1'b1, sml[22:0]} << (38 - d));
            r  = (big[31] == sml[31]) ? lv + sv : lv - sv;
            if (r == 0) begin
                res = 32'h0;
                lat = 4;
            end else begin
                p = 0;
                for (int i = 0; i < 64; i++) if (r[i]) p = i;
                e = el + p - 61;
                if (e <= 0) begin
                    res = {big[31], 31'b0};
                    lat = 4 + el;
                end else begin
                    mant = r >> (p - 23);
                    rem  = r & ((64'd1 << (p - 23)) - 64'd1);
                    half = 64'd1 << (p - 24);
`ifdef FP_ADD_RNE_EN
                    inc = (rem > half) || (rem == half && mant[0]);
`else
                    inc = 1'b0;
`endif
                    mant = mant + {63'b0, inc};
                    if (mant[24]) begin
                        mant = mant >> 1;
                        e++;
                    end
                    lat = 5 + ((p >= 61) ? 1 : (61 - p));
                    if (e >= 255) res = {big[31], 8'hFF, 23'b0};
                    else          res = {big[31], e[7:0], mant[22:0]};
                end
            end
        end
    endfunction

    // Present operands and wait for the accept edge (state must be IDLE).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        check("in_ready_before_op", {31'b0, bus.in_ready}, 32'd1);
        bus.A = a; bus.B = b; bus.sub = s; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Run one op; lat = cycle index of the first out_valid after the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] res, output int lat);
        start_op(a, b, s);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        res = bus.Sum;
        if (bus.out_ready && bus.out_valid) begin
            @(negedge clk);
            check("in_ready_after_done", {31'b0, bus.in_ready}, 32'd1);
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'h00;
            1:       v[30:0]  = 31'h7F800000;
            2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

`ifdef FP_ADD_RNE_EN
    localparam logic [31:0] RND_UP = 32'h3F800001;
`else
    localparam logic [31:0] RND_UP = 32'h3F800000;
`endif

    logic [31:0] d_a   [8] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800001,
                               32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000};
    logic [31:0] d_b   [8] = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                               32'hFF800000, 32'h7F7FFFFF, 32'h33C00000, 32'h33800000};
    logic        d_s   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] d_exp [8] = '{32'h40400000, 32'h00000000, 32'h40000000, 32'h34000000,
                               32'h7FC00000, 32'h7F800000, RND_UP,       32'h3F800000};
    int          d_lat [8] = '{6, 4, 6, 28, 2, 6, 6, 6};

    initial begin
        logic [31:0] res, a, b, exp_res;
        logic        s;
        int          lat, exp_lat, pulses;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},          32'd0);
        check("rst_sum",       bus.Sum,                32'd0);
        rst = 1'b0;

        // directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(d_a[i], d_b[i], d_s[i], res, lat);
            check($sformatf("dir%0d_sum", i), res, d_exp[i]);
            check($sformatf("dir%0d_lat", i), lat, d_lat[i]);
        end

        // randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && a[30:23] != 8'hFF && a[30:23] != 8'h00)
                b[30:23] = 8'($urandom_range(a[30:23] > 3 ? a[30:23] - 3 : 1,
                                             a[30:23] < 251 ? a[30:23] + 3 : 254));
            if ($urandom_range(0, 9) == 0) b[30:0] = a[30:0];
            ref_add(a, b, s, exp_res, exp_lat);
            run_op(a, b, s, res, lat);
            check($sformatf("rnd%0d_sum a=%h b=%h s=%0d", i, a, b, s), res, exp_res);
            check($sformatf("rnd%0d_lat", i), lat, exp_lat);
        end

        // backpressure: result held for 3 stalled DONE cycles
        bus.out_ready = 1'b0;
        run_op(32'h3F800000, 32'h40000000, 1'b0, res, lat);
        check("bp_first_sum", res, 32'h40400000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_sum_hold",  bus.Sum,                32'h40400000);
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("bp_release_out_valid", {31'b0, bus.out_valid}, 32'd0);

        // reset while in NORM aborts the op with no result
        start_op(32'h3F800001, 32'h3F800000, 1'b1);
        repeat (8) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy",      {31'b0, busy},          32'd0);
        check("abort_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("abort_no_result", pulses, 0);

        // recovery after abort
        run_op(32'h3F800000, 32'h40000000, 1'b0, res, lat);
        check("recover_sum", res, 32'h40400000);
        check("recover_lat", lat, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
